debounce_sync: RTL and testbench
================================

// Module: debounce_sync
// PURPOSE
//  Conditions a raw, asynchronous 1-bit input (switch/pin) before it drives the d_ff data path.
//  Synchronises into clk, rejects glitches shorter than a programmable stable time.
//  Emits a clean level plus single-cycle rise/fall strobes, and counts rejected glitches.
//  Sits directly upstream of the d_ff stage; the level output feeds its d input.
// PARAMETERS
//  SYNC_STAGES    2   synchroniser depth, legal >= 2
//  STABLE_CYCLES  4   confirm cycles after a change is seen, legal >= 1
//  GCNT_W         8   width of glitch counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  din          in   1       raw asynchronous input
//  glitch_clr   in   1       synchronous clear of glitch_cnt
//  level        out  1       debounced, synchronised level
//  rise         out  1       1-cycle strobe when level goes 0->1
//  fall         out  1       1-cycle strobe when level goes 1->0
//  glitch_cnt   out  GCNT_W  number of rejected transitions, saturating
// BEHAVIOUR
//  Reset: one clk; rst async active-high. On rst: all sync flops=0, state=LOW,
//   confirm counter=0, level=0, rise=0, fall=0, glitch_cnt=0. Release is sampled on the next clk edge.
//  Sync chain: s[0]<=din, s[i]<=s[i-1]; sync = s[SYNC_STAGES-1]; no logic between stages.
//  FSM states: LOW, WAIT_HI, HIGH, WAIT_LO; counter cnt width $clog2(STABLE_CYCLES+1).
//   LOW:     sync=1 -> WAIT_HI, cnt<=0; else stay.
//   WAIT_HI: sync=0 -> LOW, glitch_cnt+1; sync=1 & cnt==STABLE_CYCLES-1 -> HIGH,
//            level<=1, rise<=1; else cnt<=cnt+1.
//   HIGH:    sync=0 -> WAIT_LO, cnt<=0; else stay.
//   WAIT_LO: sync=1 -> HIGH, glitch_cnt+1; sync=0 & cnt==STABLE_CYCLES-1 -> LOW,
//            level<=0, fall<=1; else cnt<=cnt+1.
//  rise/fall: registered, high exactly one cycle, coincident with the level edge; never both high.
//  Latency: a change on din that stays stable is reflected on level at the
//   (SYNC_STAGES+STABLE_CYCLES+1)-th rising edge after din changes (first sampling edge = 1).
//   This is 7 edges at the default parameters.
//  Acceptance: a change is accepted only if sync holds the new value for STABLE_CYCLES+1
//   consecutive edges. A shorter excursion returns to the old state and increments glitch_cnt once.
//  glitch_cnt: saturates at 2^GCNT_W-1, no wrap. glitch_clr takes priority over an increment
//   in the same cycle (result 0).
//  Reset mid-WAIT: aborts the confirmation, with no strobe and no glitch count.
//  If din=1 at rst release: behaves as a normal 0->1 change; rise is asserted after the latency.
//  Width: cnt never exceeds STABLE_CYCLES-1. The design synthesises with STABLE_CYCLES=1
//   (cnt width 1).
// TESTING  (clk period 10, default params, din driven off-edge)
//  1 rst=1 at t=2, din=1 -> level=0, rise=fall=0, glitch_cnt=0 for as long as rst is held.
//  2 rst released, din 0->1 held -> level=1 and rise=1 on the 7th edge, rise=0 on the next edge.
//  3 level=1, din low for 2 cycles then high -> level stays 1, no fall, glitch_cnt=1.
//  4 din 1->0 held -> fall strobes once on the 7th edge, level=0. Then 300 glitches
//    -> glitch_cnt=255 (saturated). Then glitch_clr=1 -> glitch_cnt=0 next cycle.
//  5 din 0->1, rst pulsed 5 time units during WAIT_HI -> all outputs 0 at once.
//    Then din still 1 -> rise 7 edges after rst release.
//  6 Sweep STABLE_CYCLES=1 build: a 2-cycle-stable din is accepted; a 1-cycle din pulse
//    is rejected and glitch_cnt=1.

Source files
------------

// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw asynchronous input, producing a clean level,
// single-cycle rise/fall strobes and a saturating count of rejected glitches.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int GCNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              glitch_clr,
    output logic              level,
    output logic              rise,
    output logic              fall,
    output logic [GCNT_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GCNT_W-1:0] GCNT_MAX  = '1;

    typedef enum logic [1:0] {
        LOW,
        WAIT_HI,
        HIGH,
        WAIT_LO
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   glitch_inc;

    // Plain flop chain: no logic between stages so metastability can settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // An excursion that reverts before confirmation completes is a glitch.
    assign glitch_inc = ((state == WAIT_HI) && !sync) || ((state == WAIT_LO) && sync);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                LOW: begin
                    if (sync) begin
                        state <= WAIT_HI;
                        cnt   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync) begin
                        state <= LOW;
                    end else if (cnt == CNT_LAST) begin
                        state <= HIGH;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!sync) begin
                        state <= WAIT_LO;
                        cnt   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (sync) begin
                        state <= HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= LOW;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_inc && (glitch_cnt != GCNT_MAX)) begin
            glitch_cnt <= glitch_cnt + GCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: default build plus a STABLE_CYCLES=1 build,
// expectations queued at stimulus time and popped after each sampling point.
module tb_debounce_sync;

    logic       clk;
    logic       rst;
    logic       din;
    logic       glitchClr;
    logic       din2;
    logic       glitchClr2;
    logic       levelA;
    logic       riseA;
    logic       fallA;
    logic [7:0] gcntA;
    logic       levelB;
    logic       riseB;
    logic       fallB;
    logic [7:0] gcntB;

    typedef struct {
        string       tag;
        bit          sel;
        logic [10:0] expVec;
        logic [10:0] mask;
    } exp_t;

    exp_t scoreboard[$];
    int   assertCount = 0;
    int   failCount   = 0;

    localparam logic [10:0] M_ALL = 11'h7FF;
    localparam logic [10:0] M_LRF = 11'h700;
    localparam logic [10:0] M_G   = 11'h0FF;

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GCNT_W(8)) dutA (
        .clk(clk), .rst(rst), .din(din), .glitch_clr(glitchClr),
        .level(levelA), .rise(riseA), .fall(fallA), .glitch_cnt(gcntA)
    );

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .GCNT_W(8)) dutB (
        .clk(clk), .rst(rst), .din(din2), .glitch_clr(glitchClr2),
        .level(levelB), .rise(riseB), .fall(fallB), .glitch_cnt(gcntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input bit sel, input bit d, input bit clr);
        if (sel) begin
            din2       = d;
            glitchClr2 = clr;
        end else begin
            din       = d;
            glitchClr = clr;
        end
    endtask

    task automatic expectOut(input string tag, input bit sel, input bit lv, input bit r,
                             input bit f, input int g, input logic [10:0] mask);
        exp_t e;
        e.tag    = tag;
        e.sel    = sel;
        e.expVec = {lv, r, f, 8'(g)};
        e.mask   = mask;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [10:0] obs;
        if (scoreboard.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboard_empty: observed no entry, expected one queued");
            return;
        end
        e   = scoreboard.pop_front();
        obs = e.sel ? {levelB, riseB, fallB, gcntB} : {levelA, riseA, fallA, gcntA};
        assertCount++;
        assert ((obs & e.mask) === (e.expVec & e.mask)) else begin
            failCount++;
            $error("[TB] FAIL %s: observed {level,rise,fall,gcnt}=%h expected %h (mask %h)",
                   e.tag, obs, e.expVec, e.mask);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input bit sel, input bit d, input bit clr,
                        input bit lv, input bit r, input bit f, input int g,
                        input logic [10:0] mask);
        applyStimulus(sel, d, clr);
        expectOut(tag, sel, lv, r, f, g, mask);
        tick();
        checkOutput();
    endtask

    initial begin
        rst        = 1'b0;
        din        = 1'b0;
        glitchClr  = 1'b0;
        din2       = 1'b0;
        glitchClr2 = 1'b0;

        // Reset held with din high: everything must stay cleared.
        #2;
        rst = 1'b1;
        din = 1'b1;
        for (int i = 0; i < 3; i++) step("reset_hold", 0, 1, 0, 0, 0, 0, 0, M_ALL);
        expectOut("reset_hold_b", 1, 0, 0, 0, 0, M_ALL);
        checkOutput();

        // Release with din already high: rise on the 7th edge.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step("rise_wait", 0, 1, 0, 0, 0, 0, 0, M_ALL);
        step("rise_edge", 0, 1, 0, 1, 1, 0, 0, M_ALL);
        step("rise_clear", 0, 1, 0, 1, 0, 0, 0, M_ALL);

        // Two-cycle low dip is rejected.
        for (int i = 0; i < 2; i++) step("dip_low", 0, 0, 0, 1, 0, 0, 0, M_LRF);
        for (int i = 0; i < 4; i++) step("dip_back", 0, 1, 0, 1, 0, 0, 0, M_LRF);
        expectOut("dip_glitch_cnt", 0, 1, 0, 0, 1, M_ALL);
        checkOutput();

        // Held low: fall on the 7th edge.
        for (int i = 0; i < 6; i++) step("fall_wait", 0, 0, 0, 1, 0, 0, 1, M_ALL);
        step("fall_edge", 0, 0, 0, 0, 0, 1, 1, M_ALL);
        step("fall_clear", 0, 0, 0, 0, 0, 0, 1, M_ALL);

        // 300 one-cycle pulses: count climbs then saturates.
        for (int k = 0; k < 300; k++) begin
            step("glitch_pulse", 0, 1, 0, 0, 0, 0, 0, M_LRF);
            for (int j = 0; j < 3; j++) step("glitch_idle", 0, 0, 0, 0, 0, 0, 0, M_LRF);
            if (k == 9) begin
                expectOut("glitch_cnt_11", 0, 0, 0, 0, 11, M_G);
                checkOutput();
            end
        end
        for (int i = 0; i < 2; i++) step("glitch_saturated", 0, 0, 0, 0, 0, 0, 255, M_ALL);

        step("glitch_clr", 0, 0, 1, 0, 0, 0, 0, M_ALL);
        step("glitch_clr_hold", 0, 0, 0, 0, 0, 0, 0, M_ALL);

        // Clear coincident with an increment leaves zero.
        step("prio_pulse", 0, 1, 0, 0, 0, 0, 0, M_ALL);
        step("prio_idle", 0, 0, 0, 0, 0, 0, 0, M_ALL);
        step("prio_idle", 0, 0, 0, 0, 0, 0, 0, M_ALL);
        step("prio_clr_wins", 0, 0, 1, 0, 0, 0, 0, M_ALL);
        step("recount_pulse", 0, 1, 0, 0, 0, 0, 0, M_ALL);
        step("recount_idle", 0, 0, 0, 0, 0, 0, 0, M_ALL);
        step("recount_idle", 0, 0, 0, 0, 0, 0, 0, M_ALL);
        step("recount_one", 0, 0, 0, 0, 0, 0, 1, M_ALL);

        // Reset pulse in WAIT_HI aborts confirmation immediately.
        for (int i = 0; i < 4; i++) step("wait_hi", 0, 1, 0, 0, 0, 0, 1, M_ALL);
        rst = 1'b1;
        #2;
        expectOut("reset_async", 0, 0, 0, 0, 0, M_ALL);
        checkOutput();
        expectOut("reset_async_b", 1, 0, 0, 0, 0, M_ALL);
        checkOutput();
        #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step("rerise_wait", 0, 1, 0, 0, 0, 0, 0, M_ALL);
        step("rerise_edge", 0, 1, 0, 1, 1, 0, 0, M_ALL);
        step("rerise_clear", 0, 1, 0, 1, 0, 0, 0, M_ALL);

        // STABLE_CYCLES=1 build: two-cycle high accepted, one-cycle pulse rejected.
        step("b_high", 1, 1, 0, 0, 0, 0, 0, M_ALL);
        step("b_high", 1, 1, 0, 0, 0, 0, 0, M_ALL);
        step("b_low", 1, 0, 0, 0, 0, 0, 0, M_ALL);
        step("b_rise_edge", 1, 0, 0, 1, 1, 0, 0, M_ALL);
        step("b_rise_clear", 1, 0, 0, 1, 0, 0, 0, M_ALL);
        step("b_fall_edge", 1, 0, 0, 0, 0, 1, 0, M_ALL);
        step("b_fall_clear", 1, 0, 0, 0, 0, 0, 0, M_ALL);
        step("b_pulse", 1, 1, 0, 0, 0, 0, 0, M_ALL);
        step("b_pulse_idle", 1, 0, 0, 0, 0, 0, 0, M_ALL);
        step("b_pulse_idle", 1, 0, 0, 0, 0, 0, 0, M_ALL);
        step("b_glitch_one", 1, 0, 0, 0, 0, 0, 1, M_ALL);
        step("b_glitch_hold", 1, 0, 0, 0, 0, 0, 1, M_ALL);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
